// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants and field bundle for the encoder, main decoder and ALU decoder.
package mips_pkg;

   typedef enum logic [4:0] {
      MN_ADD  = 5'd0,  MN_SUB  = 5'd1,  MN_AND  = 5'd2,  MN_OR   = 5'd3,
      MN_SLT  = 5'd4,  MN_LW   = 5'd5,  MN_SW   = 5'd6,  MN_BEQ  = 5'd7,
      MN_ADDI = 5'd8,  MN_J    = 5'd9,  MN_MOVZ = 5'd10, MN_LHU  = 5'd11,
      MN_SLLV = 5'd12, MN_BLT  = 5'd13, MN_LI   = 5'd14, MN_MIX4 = 5'd15
   } mnem_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_MOVZ  = 6'b001010;
   localparam logic [5:0] OP_LHU   = 6'b100101;
   localparam logic [5:0] OP_BLT   = 6'b011101;
   localparam logic [5:0] OP_LI    = 6'b010001;
   localparam logic [5:0] OP_MIX4  = 6'b110011;

   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_SLT   = 6'b101010;
   localparam logic [5:0] FN_SLLV  = 6'b000100;
   localparam logic [5:0] FN_NONE  = 6'b000000;

   typedef struct packed {
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  shamt;
      logic [15:0] imm;
      logic [25:0] target;
   } instr_fields_t;

   function automatic logic [31:0] r_word(input logic [5:0] op, input instr_fields_t f,
                                          input logic [4:0] shamt, input logic [5:0] fn);
      return {op, f.rs, f.rt, f.rd, shamt, fn};
   endfunction

   function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational mnemonic-to-word packer; flags codes with no encoding as illegal.
// Custom ops (codes 10-15) are encoded only when CUSTOM_OPS_EN is defined.
module instr_pack
   import mips_pkg::*;
(
   input  logic [4:0]    mnem,
   input  instr_fields_t f,
   output logic [31:0]   word,
   output logic          illegal
);

   always_comb begin
      word    = '0;
      illegal = 1'b0;
      case (mnem)
         MN_ADD:  word = r_word(OP_RTYPE, f, f.shamt, FN_ADD);
         MN_SUB:  word = r_word(OP_RTYPE, f, f.shamt, FN_SUB);
         MN_AND:  word = r_word(OP_RTYPE, f, f.shamt, FN_AND);
         MN_OR:   word = r_word(OP_RTYPE, f, f.shamt, FN_OR);
         MN_SLT:  word = r_word(OP_RTYPE, f, f.shamt, FN_SLT);
         MN_LW:   word = i_word(OP_LW,   f.rs, f.rt, f.imm);
         MN_SW:   word = i_word(OP_SW,   f.rs, f.rt, f.imm);
         MN_BEQ:  word = i_word(OP_BEQ,  f.rs, f.rt, f.imm);
         MN_ADDI: word = i_word(OP_ADDI, f.rs, f.rt, f.imm);
         MN_J:    word = {OP_J, f.target};
`ifdef CUSTOM_OPS_EN
         MN_MOVZ: word = r_word(OP_MOVZ, f, f.shamt, FN_NONE);
         MN_MIX4: word = r_word(OP_MIX4, f, f.shamt, FN_NONE);
         // SLLV takes its shift amount from rs, so the shamt field stays zero
         MN_SLLV: word = r_word(OP_RTYPE, f, 5'd0, FN_SLLV);
         MN_LHU:  word = i_word(OP_LHU, f.rs, f.rt, f.imm);
         MN_BLT:  word = i_word(OP_BLT, f.rs, f.rt, f.imm);
         MN_LI:   word = i_word(OP_LI,  5'd0, f.rt, f.imm);
`endif
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Streams symbolic instructions into imem at an auto-incrementing address; 1-cycle latency,
// 1 word/cycle. in_ready drops when imem is full or on restart. Custom ops need CUSTOM_OPS_EN.
module instr_encoder
   import mips_pkg::*;
#(
   parameter int AW        = 6,
   parameter int BASE_ADDR = 0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          restart,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [4:0]    in_mnem,
   input  logic [4:0]    in_rs,
   input  logic [4:0]    in_rt,
   input  logic [4:0]    in_rd,
   input  logic [4:0]    in_shamt,
   input  logic [15:0]   in_imm,
   input  logic [25:0]   in_target,
   output logic          imem_we,
   output logic [AW-1:0] imem_addr,
   output logic [31:0]   imem_wd,
   output logic          err,
   output logic          full,
   output logic [AW:0]   count
);

   localparam logic [AW-1:0] BASE    = AW'(BASE_ADDR);
   localparam logic [AW-1:0] PTR_MAX = '1;
   localparam logic [AW:0]   CNT_MAX = {1'b1, {AW{1'b0}}};

   instr_fields_t fields;
   logic [31:0]   word;
   logic          illegal;
   logic [AW-1:0] ptr;
   logic          accept;
   logic          do_write;

   assign fields   = {in_rs, in_rt, in_rd, in_shamt, in_imm, in_target};
   assign in_ready = !full && !restart;
   assign accept   = in_valid && in_ready;
   assign do_write = accept && !illegal;

   instr_pack u_pack (
      .mnem    (in_mnem),
      .f       (fields),
      .word    (word),
      .illegal (illegal)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         imem_we   <= 1'b0;
         imem_addr <= '0;
         imem_wd   <= '0;
         err       <= 1'b0;
         full      <= 1'b0;
         count     <= '0;
         ptr       <= BASE;
      end else begin
         imem_we <= do_write;
         err     <= accept && illegal;
         if (do_write) begin
            imem_addr <= ptr;
            imem_wd   <= word;
         end
         // restart and accept are exclusive because in_ready is gated by restart
         if (restart) begin
            ptr   <= BASE;
            count <= '0;
            full  <= 1'b0;
         end else if (do_write) begin
            if (ptr == PTR_MAX) full <= 1'b1;
            else                ptr  <= ptr + 1'b1;
            if (count != CNT_MAX) count <= count + 1'b1;
         end
      end
   end

endmodule
